tick_gen: RTL

//   Programmable prescaler and burst sequencer. Emits single-cycle tick strobes every DIV clocks.

---
 rtl/tick_gen_if.sv | 27 ++
 rtl/tick_gen.sv | 115 +++++++++++
 2 files changed

// File: rtl/tick_gen_if.sv
// Control/status bundle for tick_gen.
// master: the controlling FSM (drives commands, reads status).
// slave:  the tick generator itself.
interface tick_gen_if #(
  parameter int W = 16,
  parameter int B = 8
);
  logic         start;
  logic         stop;
  logic         pause;
  logic [W-1:0] div;
  logic [B-1:0] burst;
  logic         tick;
  logic         done;
  logic         busy;
  logic [B-1:0] ticks_left;

  modport master (
    output start, stop, pause, div, burst,
    input  tick, done, busy, ticks_left
  );

  modport slave (
    input  start, stop, pause, div, burst,
    output tick, done, busy, ticks_left
  );
endinterface

// File: rtl/tick_gen.sv
// Programmable prescaler and burst sequencer.
// Emits a registered one-cycle tick every div_eff clocks while running.
// Supports free-run (burst == 0) or fixed-length bursts, pause/resume and abort.
// Command priority each cycle: rst > stop > start > pause > normal count.
// Optional feature macro TICK_GEN_LIVE_DIV_EN: when defined, div is re-sampled
// at every prescaler wrap so a new period takes effect from the next period;
// otherwise div is captured only on start.
module tick_gen #(
  parameter int W = 16,
  parameter int B = 8
) (
  input  logic       clk,
  input  logic       rst,
  tick_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE_W = W'(1);
  localparam logic [B-1:0] ONE_B = B'(1);

  state_t       state, state_n;
  logic [W-1:0] presc, presc_n;
  logic [W-1:0] div_q, div_n;
  logic [B-1:0] left, left_n;
  logic         tick_r, tick_n;
  logic         done_r, done_n;
  logic         wrap;

  // A zero divisor behaves like a divisor of one (tick every cycle).
  function automatic logic [W-1:0] div_eff(input logic [W-1:0] d);
    return (d == '0) ? ONE_W : d;
  endfunction

  // div_q is never below 1, so this compare cannot underflow.
  assign wrap = (presc == (div_q - ONE_W));

  // Next-state and next-output decode, following the command priority order.
  always_comb begin
    state_n = state;
    presc_n = presc;
    left_n  = left;
    div_n   = div_q;
    tick_n  = 1'b0;
    done_n  = 1'b0;
    if (bus.stop) begin
      state_n = IDLE;
      presc_n = '0;
      left_n  = '0;
    end else if (bus.start) begin
      state_n = RUN;
      presc_n = '0;
      left_n  = bus.burst;
      div_n   = div_eff(bus.div);
    end else if (state != IDLE) begin
      if (bus.pause) begin
        // Hold prescaler and remaining count; no tick while paused.
        state_n = PAUSED;
      end else begin
        // Leaving PAUSED counts on the same edge, so a pause costs exactly
        // as many cycles as pause was held high.
        state_n = RUN;
        if (wrap) begin
          presc_n = '0;
          tick_n  = 1'b1;
`ifdef TICK_GEN_LIVE_DIV_EN
          div_n   = div_eff(bus.div);
`endif
          // Non-zero left while busy means burst mode; free-run keeps it 0.
          if (left != '0) begin
            left_n = left - ONE_B;
            if (left == ONE_B) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end
        end else begin
          presc_n = presc + ONE_W;
        end
      end
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      presc  <= '0;
      left   <= '0;
      tick_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      presc  <= presc_n;
      left   <= left_n;
      tick_r <= tick_n;
      done_r <= done_n;
    end
  end

  // Latched period; only consulted while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    div_q <= div_n;
  end

  assign bus.tick       = tick_r;
  assign bus.done       = done_r;
  assign bus.busy       = (state != IDLE);
  assign bus.ticks_left = left;

endmodule
